// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor controller driving one external 1-bit
// full-adder cell (prop/gen/sout), LSB first, one bit per clock.
module bit_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_prop,
    input  logic             fa_gen,
    input  logic             fa_sout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             carry_next;
    logic [WIDTH-1:0] res_next;

    // Cell inputs depend only on flops, so the external cell never closes a loop.
    assign fa_a   = (state_q == S_RUN) & opa_q[0];
    assign fa_b   = (state_q == S_RUN) & opb_q[0];
    assign fa_cin = (state_q == S_RUN) & carry_q;

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

    assign carry_next = fa_gen | (fa_prop & carry_q);
    assign res_next   = {fa_sout, res_q[WIDTH-1:1]};

    // Next-state and datapath update for the serial add sequence.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                res_d   = res_next;
                carry_d = carry_next;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                // carry_q here is the carry into the MSB; carry_next is out of it.
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_next;
                    cout_d  = carry_next;
                    ovf_d   = carry_q ^ carry_next;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed bench for bit_serial_add_ctrl with a behavioural full-adder cell
// and a queue of expected results checked when done pulses.
module tb_bit_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, sub;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;
    logic       fa_a, fa_b, fa_cin, fa_prop, fa_gen, fa_sout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;
    exp_t sb_q[$];
    logic last_sub;

    always #5 clk = ~clk;

    assign fa_prop = fa_a ^ fa_b;
    assign fa_gen  = fa_a & fa_b;
    assign fa_sout = fa_a ^ fa_b ^ fa_cin;

    bit_serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_prop(fa_prop), .fa_gen(fa_gen), .fa_sout(fa_sout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a start in the current cycle (cycle 0) and queue its expected result.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                            input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        a = av; b = bv; sub = sv; start = 1'b1;
        last_sub = sv;
        e.s = es; e.c = ec; e.o = eo;
        sb_q.push_back(e);
    endtask

    // Walk cycles 1..10 of an operation; optionally re-pulse start in cycles 3 and 9.
    task automatic check_run(input string tag, input logic [7:0] prev_sum, input bit pulse);
        exp_t e;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (pulse && (c == 3)) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
            end else begin
                start = 1'b0;
            end
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            chk({tag, "_held"}, 32'(sum), 32'(prev_sum));
            if (c == 1) chk({tag, "_cin0"}, 32'(fa_cin), 32'(last_sub));
        end
        tick();
        if (pulse) begin
            start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
        end else begin
            start = 1'b0;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy9"}, 32'(busy), 32'd0);
        chk({tag, "_fa_idle"}, 32'({fa_a, fa_b, fa_cin}), 32'd0);
        if (done) begin
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk({tag, "_sum"}, 32'(sum), 32'(e.s));
                chk({tag, "_cout"}, 32'(cout), 32'(e.c));
                chk({tag, "_ovf"}, 32'(ovf), 32'(e.o));
            end
        end
        tick();
        start = 1'b0;
        chk({tag, "_done10"}, 32'(done), 32'd0);
        chk({tag, "_busy10"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00; last_sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_outs", 32'({sum, cout, ovf}), 32'd0);
        chk("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        tick();

        start_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        check_run("t1", 8'h00, 1'b0);
        start_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        check_run("t2a", 8'h7F, 1'b0);
        start_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        check_run("t2b", 8'h00, 1'b0);
        start_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        check_run("t3a", 8'h80, 1'b0);
        start_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        check_run("t3b", 8'hF0, 1'b0);

        start_op(8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);
        check_run("t4", 8'h7F, 1'b1);
        tick();
        chk("t4_done_once", 32'(done), 32'd0);
        chk("t4_no_restart", 32'(busy), 32'd0);

        // Abort mid-run: reset asserted during cycle 4.
        start_op(8'h55, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb_q.pop_back());
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_outs", 32'({sum, cout, ovf}), 32'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t5_nodone", 32'(done), 32'd0);
        end
        start_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
        check_run("t5b", 8'h00, 1'b0);

        start_op(8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0, 1'b0);
        chk("t6_held0", 32'(sum), 32'h03);
        check_run("t6", 8'h03, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
